mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store unit of the five-stage MIPS pipeline. Accepts one memory operation per instruction from the EX/MEM register and runs a request/address-ok/data-ok handshake on the data SRAM-like bus. Stalls the pipeline while the bus transaction is outstanding. Byte-lanes store data and write strobes; for loads, extracts the addressed byte or halfword and sign- or zero-extends it to 32 bits for MEM/WB.

## Interface
- ADDR_W, 32, address width; data path fixed at 32 bits.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a load/store.
- mem_we  in  1  1 = store, 0 = load.
- mem_size  in  2  0 byte, 1 half, 2 word; 3 is treated as word.
- mem_unsigned  in  1  load zero-extends (LBU/LHU); ignored for stores and words.
- mem_addr  in  ADDR_W  virtual = physical address.
- mem_wdata  in  32  store data, right-aligned.
- flush  in  1  exception/redirect flush of the MEM stage.
- stall  out  1  holds all earlier pipeline registers.
- load_valid  out  1  one-cycle pulse; load_data valid.
- load_data  out  32  extended load result.
- addr_err  out  1  misaligned access (see Configuration).
- bad_vaddr  out  ADDR_W  faulting address, valid with addr_err.
- data_req, data_wr  out  1  bus request, write flag.
- data_size  out  2  copy of mem_size.
- data_addr  out  ADDR_W  request address.
- data_wstrb  out  4  byte write strobes.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok, data_data_ok  in  1  bus address accept, data return / write done.
- data_rdata  in  32  raw read word.

## Operation
- States: IDLE, REQ, WAIT, DONE. All captured payload (addr, size, we, unsigned, wdata) is registered on acceptance.
- IDLE:
  - mem_valid & aligned & !flush: capture payload; stall=1; go to REQ.
  - Misaligned: no capture, no bus request.
- REQ:
  - data_req=1; payload held stable; stall=1.
  - data_addr_ok & data_data_ok: go to DONE.
  - data_addr_ok only: go to WAIT.
  - flush before data_addr_ok: drop data_req, go to IDLE.
- WAIT:
  - stall=1; data_data_ok: latch data_rdata and go to DONE.
  - flush: set the cancelled flag; keep waiting; on data_data_ok go to IDLE without DONE.
- DONE:
  - stall=0; load_valid=1 for uncancelled loads only; go to IDLE unconditionally. The stale mem_valid is never re-accepted.
- Store lanes:
  - Byte: wdata={4{b}}, wstrb=4'b0001<<addr[1:0].
  - Half: wdata={2{h}}, wstrb=4'b0011<<addr[1:0].
  - Word: wstrb=4'b1111.
  - Loads: wstrb=0.
- Load extract:
  - Byte = rdata>>(8*addr[1:0]), extended from bit 7.
  - Half = rdata>>(16*addr[1]), extended from bit 15.
  - mem_unsigned selects zero-extension.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0.
- Reset, any state: state=IDLE immediately; data_req drops asynchronously; any in-flight transaction is abandoned.
- Reset values: all outputs 0; load_data=0; bad_vaddr=0.

## Timing
- stall is combinational from state and IDLE-cycle inputs.
- load_data and load_valid are registered, presented in DONE.
- Minimum load/store latency: 3 cycles (accept, REQ with same-cycle addr_ok+data_ok, DONE).
- stall is high for all but the DONE cycle.
- data_req never asserts in IDLE, so there is no combinational path from mem_* to data_req.
- flush and data_addr_ok in the same REQ cycle: the address is already taken, so go to WAIT cancelled.

## Configuration
- MEM_ADDR_ERR_EN defined:
  - Misaligned access in IDLE with mem_valid & !flush: addr_err=1 and bad_vaddr=mem_addr combinationally.
  - stall=0; no bus request.
- MEM_ADDR_ERR_EN undefined:
  - addr_err and bad_vaddr tied to 0.
  - Low address bits are forced aligned (half clears bit 0, word clears bits 1:0) and the access proceeds normally.

## Test plan
- LB at 0x0000_1003, data_rdata 0x80FF_1234 -> load_data 0xFFFF_FF80 in DONE; same with LBU -> 0x0000_0080.
- SH at 0x0000_2002, mem_wdata 0x0000_BEEF -> data_wstrb 4'b1100, data_wdata 0xBEEF_BEEF, data_size 1, data_wr 1; load_valid stays 0.
- LW at 0x0000_3000 with addr_ok 3 cycles after REQ, data_ok 2 cycles later (rdata 0xDEAD_BEEF):
  - data_addr stable for all REQ cycles; stall high for 7 cycles.
  - Exactly one load_valid pulse with 0xDEAD_BEEF.
- LW at 0x0000_4001 with MEM_ADDR_ERR_EN -> addr_err 1, bad_vaddr 0x0000_4001, data_req never asserted, stall 0.
- LH accepted, flush in WAIT, data_ok 2 cycles later -> load_valid 0, back to IDLE; next LW accepted on the following cycle.
- rst pulsed mid-REQ -> data_req falls before the next clk edge and all outputs return to 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives an SRAM-like req/addr_ok/data_ok bus and extends loads.
// Define MEM_ADDR_ERR_EN to trap misaligned accesses; otherwise low address bits are force-aligned.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              addr_err,
    output logic [ADDR_W-1:0] bad_vaddr,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic              load_valid_q, load_valid_d;
    logic [31:0]       load_data_q, load_data_d;

    logic              is_word_in, is_half_in, offer, accept;
    logic [ADDR_W-1:0] acc_addr;

    assign is_word_in = mem_size[1];
    assign is_half_in = (mem_size == 2'd1);
    assign offer      = (state_q == IDLE) & mem_valid & ~flush;

`ifdef MEM_ADDR_ERR_EN
    logic misaligned;
    assign misaligned = (is_word_in & (|mem_addr[1:0])) | (is_half_in & mem_addr[0]);
    assign accept     = offer & ~misaligned;
    assign addr_err   = offer & misaligned;
    assign bad_vaddr  = addr_err ? mem_addr : '0;
    assign acc_addr   = mem_addr;
`else
    assign accept     = offer;
    assign addr_err   = 1'b0;
    assign bad_vaddr  = '0;
    assign acc_addr   = {mem_addr[ADDR_W-1:2],
                         mem_addr[1] & ~is_word_in,
                         mem_addr[0] & ~is_word_in & ~is_half_in};
`endif

    assign stall = (state_q == REQ) | (state_q == WAIT) | accept;

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = REQ;
                    cancel_d = 1'b0;
                end
            end
            REQ: begin
                // Once the address is taken the slave owes us a data_ok, so a flush must wait it out.
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = flush ? IDLE : DONE;
                    end else begin
                        state_d  = WAIT;
                        cancel_d = flush;
                    end
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (data_data_ok) begin
                    state_d = (cancel_q | flush) ? IDLE : DONE;
                end else if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    assign rd_byte = data_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = data_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data_d = data_rdata;
        case (size_q)
            2'd0:    load_data_d = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
            2'd1:    load_data_d = {{16{rd_half[15] & ~uns_q}}, rd_half};
            default: load_data_d = data_rdata;
        endcase
    end

    assign load_valid_d = (state_d == DONE) & ~we_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cancel_q     <= 1'b0;
            addr_q       <= '0;
            size_q       <= 2'd0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= 32'd0;
            load_valid_q <= 1'b0;
            load_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cancel_q     <= cancel_d;
            load_valid_q <= load_valid_d;
            if (load_valid_d) begin
                load_data_q <= load_data_d;
            end
            if (accept) begin
                addr_q  <= acc_addr;
                size_q  <= mem_size;
                we_q    <= mem_we;
                uns_q   <= mem_unsigned;
                wdata_q <= mem_wdata;
            end
        end
    end

    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;
    assign data_req   = (state_q == REQ);
    assign data_wr    = we_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;

    always_comb begin
        data_wstrb = 4'b0000;
        if (we_q) begin
            case (size_q)
                2'd0:    data_wstrb = 4'b0001 << addr_q[1:0];
                2'd1:    data_wstrb = 4'b0011 << addr_q[1:0];
                default: data_wstrb = 4'b1111;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign data_wdata[8*gi +: 8] = (size_q == 2'd0) ? wdata_q[7:0] :
                                           (size_q == 2'd1) ? wdata_q[8*(gi%2) +: 8] :
                                                              wdata_q[8*gi +: 8];
        end
    endgenerate
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected bus/load results, a monitor checks them.
module tb_mem_access_unit;
    logic        clk, rst;
    logic        mem_valid, mem_we, mem_unsigned, flush;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, load_valid, addr_err;
    logic [31:0] load_data, bad_vaddr;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush),
        .stall(stall), .load_valid(load_valid), .load_data(load_data), .addr_err(addr_err),
        .bad_vaddr(bad_vaddr), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_load[$];
    int          errors = 0;
    int          checks = 0;
    int          lv_count = 0;
    int          a_cnt = 0;
    int          d_dly = 0;
    logic [31:0] rsp_rdata = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Bus slave: addr_ok after a_cnt REQ cycles, data_ok d_dly cycles after addr_ok.
    initial begin : responder
        bit pend;
        int dcnt;
        pend = 0;
        dcnt = 0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0BAD_F00D;
        forever begin
            @(negedge clk);
            #2;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = 32'h0BAD_F00D;
            if (rst) begin
                pend = 0;
            end else if (pend) begin
                if (dcnt == 0) begin
                    data_data_ok = 1'b1;
                    data_rdata   = rsp_rdata;
                    pend         = 0;
                end else begin
                    dcnt--;
                end
            end else if (data_req) begin
                if (a_cnt == 0) begin
                    data_addr_ok = 1'b1;
                    if (d_dly == 0) begin
                        data_data_ok = 1'b1;
                        data_rdata   = rsp_rdata;
                    end else begin
                        pend = 1;
                        dcnt = d_dly - 1;
                    end
                end else begin
                    a_cnt--;
                end
            end
        end
    end

    initial begin : monitor
        bus_t e;
        forever begin
            @(negedge clk);
            #3;
            if (data_req) begin
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got req addr %h expected no request", data_addr);
                end else begin
                    chk("bus_addr", data_addr, exp_bus[0].addr);
                    if (data_addr_ok) begin
                        e = exp_bus.pop_front();
                        chk("bus_wr", 32'(data_wr), 32'(e.wr));
                        chk("bus_size", 32'(data_size), 32'(e.size));
                        chk("bus_wstrb", 32'(data_wstrb), 32'(e.wstrb));
                        chk("bus_wdata", data_wdata, e.wdata);
                    end
                end
            end
            if (load_valid) begin
                lv_count++;
                if (exp_load.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL load_unexpected: got load_valid data %h expected none", load_data);
                end else begin
                    chk("load_data", load_data, exp_load.pop_front());
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_load_valid"}, 32'(load_valid), 0);
        chk({tag, "_load_data"}, load_data, 0);
        chk({tag, "_addr_err"}, 32'(addr_err), 0);
        chk({tag, "_bad_vaddr"}, bad_vaddr, 0);
        chk({tag, "_data_req"}, 32'(data_req), 0);
        chk({tag, "_data_wr"}, 32'(data_wr), 0);
        chk({tag, "_data_size"}, 32'(data_size), 0);
        chk({tag, "_data_addr"}, data_addr, 0);
        chk({tag, "_data_wstrb"}, 32'(data_wstrb), 0);
        chk({tag, "_data_wdata"}, data_wdata, 0);
    endtask

    // Called at a negedge; returns just after the posedge that ends the DONE cycle.
    task automatic issue(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int adly,
                         input int ddly, input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata,
                         input logic [31:0] e_ld);
        bus_t b;
        int   st, lv0;
        bit   done;
        b.addr = e_addr; b.wr = we; b.size = sz; b.wstrb = e_strb; b.wdata = e_wdata;
        exp_bus.push_back(b);
        if (!we) exp_load.push_back(e_ld);
        a_cnt = adly; d_dly = ddly; rsp_rdata = rdata;
        mem_valid = 1'b1; mem_we = we; mem_size = sz; mem_unsigned = uns;
        mem_addr = addr; mem_wdata = wd;
        lv0 = lv_count; st = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            #1;
            if (stall) begin
                st++;
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got stall stuck high expected completion", nm);
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        chk({nm, "_stall_cycles"}, st, 2 + adly + ddly);
        chk({nm, "_load_pulses"}, lv_count - lv0, we ? 0 : 1);
        $display("txn %s addr=%h we=%0d size=%0d stall_cycles=%0d", nm, addr, we, sz, st);
    endtask

    initial begin : stimulus
        int  st, lv0;
        bit  saw_req;
        rst = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; mem_size = 2'd0;
        mem_unsigned = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        issue("LB",   0, 2'd0, 0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 32'h0000_1003, 4'h0, 32'h0, 32'hFFFF_FF80);
        @(negedge clk);
        issue("LBU",  0, 2'd0, 1, 32'h0000_1003, 32'h0, 1, 0, 32'h80FF_1234, 32'h0000_1003, 4'h0, 32'h0, 32'h0000_0080);
        @(negedge clk);
        issue("SH",   1, 2'd1, 0, 32'h0000_2002, 32'h0000_BEEF, 0, 1, 32'h0, 32'h0000_2002, 4'hC, 32'hBEEF_BEEF, 32'h0);
        @(negedge clk);
        issue("SB",   1, 2'd0, 0, 32'h0000_2001, 32'h0000_00A5, 0, 0, 32'h0, 32'h0000_2001, 4'h2, 32'hA5A5_A5A5, 32'h0);
        @(negedge clk);
        issue("SW",   1, 2'd2, 0, 32'h0000_2004, 32'h1234_5678, 2, 0, 32'h0, 32'h0000_2004, 4'hF, 32'h1234_5678, 32'h0);
        @(negedge clk);
        issue("LH",   0, 2'd1, 0, 32'h0000_1002, 32'h0, 0, 0, 32'h80FF_1234, 32'h0000_1002, 4'h0, 32'h0, 32'hFFFF_80FF);
        @(negedge clk);
        issue("LHU",  0, 2'd1, 1, 32'h0000_1002, 32'h0, 0, 0, 32'h80FF_1234, 32'h0000_1002, 4'h0, 32'h0, 32'h0000_80FF);
        @(negedge clk);
        issue("LH0",  0, 2'd1, 0, 32'h0000_1000, 32'h0, 0, 0, 32'h80FF_1234, 32'h0000_1000, 4'h0, 32'h0, 32'h0000_1234);
        @(negedge clk);
        issue("LW",   0, 2'd2, 0, 32'h0000_3000, 32'h0, 3, 2, 32'hDEAD_BEEF, 32'h0000_3000, 4'h0, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk);
        issue("LW3",  0, 2'd3, 0, 32'h0000_3004, 32'h0, 0, 0, 32'hCAFE_F00D, 32'h0000_3004, 4'h0, 32'h0, 32'hCAFE_F00D);
        @(negedge clk);

`ifdef MEM_ADDR_ERR_EN
        mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0;
        mem_addr = 32'h0000_4001; mem_wdata = 32'h0;
        saw_req = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (i == 0) begin
                chk("mis_addr_err", 32'(addr_err), 1);
                chk("mis_bad_vaddr", bad_vaddr, 32'h0000_4001);
                chk("mis_stall", 32'(stall), 0);
            end
            if (data_req) saw_req = 1;
            @(negedge clk);
        end
        chk("mis_no_req", 32'(saw_req), 0);
        mem_valid = 1'b0;
        #1;
        chk("mis_addr_err_clear", 32'(addr_err), 0);
        $display("txn LW_mis addr=%h addr_err_trap", 32'h0000_4001);
        @(negedge clk);
`else
        issue("LW_mis", 0, 2'd2, 0, 32'h0000_4001, 32'h0, 0, 0, 32'h1122_3344, 32'h0000_4000, 4'h0, 32'h0, 32'h1122_3344);
        @(negedge clk);
`endif

        // LH cancelled by a flush while waiting for data
        begin
            bus_t b;
            b.addr = 32'h0000_5002; b.wr = 1'b0; b.size = 2'd1; b.wstrb = 4'h0; b.wdata = 32'h0;
            exp_bus.push_back(b);
        end
        a_cnt = 0; d_dly = 3; rsp_rdata = 32'h1234_5678;
        mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'd1; mem_unsigned = 1'b0;
        mem_addr = 32'h0000_5002; mem_wdata = 32'h0;
        lv0 = lv_count; st = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (stall) st++;
            @(negedge clk);
            if (i == 1) begin
                flush = 1'b1;
                mem_valid = 1'b0;
            end else begin
                flush = 1'b0;
            end
        end
        #1;
        chk("flush_stall_cycles", st, 5);
        chk("flush_idle_stall", 32'(stall), 0);
        chk("flush_load_pulses", lv_count - lv0, 0);
        $display("txn LH_flush addr=%h stall_cycles=%0d", 32'h0000_5002, st);
        issue("LW_after_flush", 0, 2'd2, 0, 32'h0000_5004, 32'h0, 0, 0, 32'h7654_3210, 32'h0000_5004, 4'h0, 32'h0, 32'h7654_3210);
        @(negedge clk);

        // reset asserted mid-REQ with the slave never accepting the address
        begin
            bus_t b;
            b.addr = 32'h0000_6000; b.wr = 1'b1; b.size = 2'd2; b.wstrb = 4'hF; b.wdata = 32'hA5A5_5A5A;
            exp_bus.push_back(b);
        end
        a_cnt = 1000; d_dly = 0;
        mem_valid = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_unsigned = 1'b0;
        mem_addr = 32'h0000_6000; mem_wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        #1;
        chk("rst_req_before", 32'(data_req), 1);
        #2;
        rst = 1'b1;
        mem_valid = 1'b0;
        #1;
        chk_all_zero("midreq_rst");
        $display("txn SW_rst addr=%h reset_mid_req", 32'h0000_6000);
        @(negedge clk);
        rst = 1'b0;
        exp_bus.delete();
        a_cnt = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_req", 32'(data_req), 0);
        chk("post_rst_queue", exp_load.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
